// File: rtl/bilinear_fetch4.sv
// bilinear_fetch4: fetches the 2x2 pixel neighbourhood at (req_x, req_y) from
// an 8-bit image memory with one-cycle read latency, one read per cycle.
//
// Optional feature macro: FETCH_EDGE_CLAMP_EN
//   defined   -> coordinates are clamped to the image, zero dimensions read as 1
//   undefined -> x0=x, x1=x+1, y0=y, y1=y+1 unclamped; addresses wrap
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_x, req_y          top-left source pixel coordinate
//   img_w, img_h          image dimensions in pixels
//   base_addr             address of pixel (0,0)
//   mem_raddr, mem_rdata  image memory read port (data one cycle after address)
//   out_valid/out_ready   quad handshake
//   p00, p01, p10, p11    pixels (x0,y0), (x1,y0), (x0,y1), (x1,y1)
//   busy                  fetch in progress (not idle)
module bilinear_fetch4 #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIM_W-1:0]  req_x,
  input  logic [DIM_W-1:0]  req_y,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        p00,
  output logic [7:0]        p01,
  output logic [7:0]        p10,
  output logic [7:0]        p11,
  output logic              busy
);

  // One extra bit so x+1 / y+1 never wrap inside the coordinate domain.
  localparam int unsigned CW = DIM_W + 1;

  typedef enum logic [2:0] {StIdle, StA0, StA1, StA2, StA3, StCap, StOut} state_e;

  state_e state_q, state_d;

  logic [DIM_W-1:0]  x_q, y_q, w_q, h_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] raddr_hold_q;
  logic [7:0]        p00_q, p01_q, p10_q, p11_q;

  logic [CW-1:0]     w_eff, x0, x1, y0, y1, ax, ay;
  logic [ADDR_W-1:0] addr_calc;
  logic              accept;

  assign accept = (state_q == StIdle) && req_valid;

  // Neighbour coordinates from the latched request.
`ifdef FETCH_EDGE_CLAMP_EN
  logic [CW-1:0] h_eff;
  always_comb begin
    w_eff = (w_q == '0) ? CW'(1) : CW'(w_q);
    h_eff = (h_q == '0) ? CW'(1) : CW'(h_q);
    x0    = (CW'(x_q) > w_eff - CW'(1)) ? w_eff - CW'(1) : CW'(x_q);
    y0    = (CW'(y_q) > h_eff - CW'(1)) ? h_eff - CW'(1) : CW'(y_q);
    x1    = (x0 + CW'(1) > w_eff - CW'(1)) ? w_eff - CW'(1) : x0 + CW'(1);
    y1    = (y0 + CW'(1) > h_eff - CW'(1)) ? h_eff - CW'(1) : y0 + CW'(1);
  end
`else
  // Height only matters for clamping.
  logic unused_h;
  assign unused_h = ^h_q;
  always_comb begin
    w_eff = CW'(w_q);
    x0    = CW'(x_q);
    y0    = CW'(y_q);
    x1    = CW'(x_q) + CW'(1);
    y1    = CW'(y_q) + CW'(1);
  end
`endif

  // Pick the neighbour addressed in the current state.
  always_comb begin
    ax = x0;
    ay = y0;
    unique case (state_q)
      StA1:    begin ax = x1; ay = y0; end
      StA2:    begin ax = x0; ay = y1; end
      StA3:    begin ax = x1; ay = y1; end
      default: begin ax = x0; ay = y0; end
    endcase
  end

  // Only the low ADDR_W bits of each term survive the modulo, so truncate
  // operands first and let the arithmetic wrap naturally.
  assign addr_calc = base_q + ADDR_W'(ay) * ADDR_W'(w_eff) + ADDR_W'(ax);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StA0;
      StA0:    state_d = StA1;
      StA1:    state_d = StA2;
      StA2:    state_d = StA3;
      StA3:    state_d = StCap;
      StCap:   state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      base_q       <= '0;
      raddr_hold_q <= '0;
      p00_q        <= '0;
      p01_q        <= '0;
      p10_q        <= '0;
      p11_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q    <= req_x;
        y_q    <= req_y;
        w_q    <= img_w;
        h_q    <= img_h;
        base_q <= base_addr;
      end
      // Read data lags the address by one state.
      if (state_q == StA1)  p00_q <= mem_rdata;
      if (state_q == StA2)  p01_q <= mem_rdata;
      if (state_q == StA3)  p10_q <= mem_rdata;
      if (state_q == StCap) p11_q <= mem_rdata;
      // Last issued address is held outside A0..A3.
      if (state_q == StA3)  raddr_hold_q <= addr_calc;
    end
  end

  always_comb begin
    mem_raddr = raddr_hold_q;
    if (state_q inside {StA0, StA1, StA2, StA3}) mem_raddr = addr_calc;
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StOut);
  assign p00       = p00_q;
  assign p01       = p01_q;
  assign p10       = p10_q;
  assign p11       = p11_q;

endmodule

// File: tb/tb_bilinear_fetch4.sv
// Self-checking bench for bilinear_fetch4: directed corner cases plus random
// fetches compared against an arithmetic reference of the addressing rules.
module tb_bilinear_fetch4;

  localparam int ADDR_W = 19;
  localparam int DIM_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [DIM_W-1:0]  req_x, req_y, img_w, img_h;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        p00, p01, p10, p11;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  bilinear_fetch4 #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .img_w     (img_w),
    .img_h     (img_h),
    .base_addr (base_addr),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p00       (p00),
    .p01       (p01),
    .p10       (p10),
    .p11       (p11),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Image memory contents as a pure function of address.
  function automatic logic [7:0] mem_fn(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'hA5;
  endfunction

  always @(posedge clk) mem_rdata <= mem_fn(mem_raddr);

  function automatic logic [ADDR_W-1:0] ref_addr(input longint base, input longint w,
                                                 input longint x, input longint y);
    longint s;
    s = (base + y * w + x) % (longint'(1) << ADDR_W);
    return ADDR_W'(s);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch; called one time unit after a rising edge with DUT idle.
  task automatic run_fetch(input int x, input int y, input int w, input int h,
                           input int base, input int stall, input bit perturb);
    longint we, he, ex0, ex1, ey0, ey1;
    logic [ADDR_W-1:0] ea[4];
    logic [7:0] ep[4];
`ifdef FETCH_EDGE_CLAMP_EN
    we  = (w == 0) ? 1 : w;
    he  = (h == 0) ? 1 : h;
    ex0 = (x > we - 1) ? we - 1 : x;
    ey0 = (y > he - 1) ? he - 1 : y;
    ex1 = (ex0 + 1 > we - 1) ? we - 1 : ex0 + 1;
    ey1 = (ey0 + 1 > he - 1) ? he - 1 : ey0 + 1;
`else
    we  = w;
    he  = h;
    ex0 = x;
    ey0 = y;
    ex1 = longint'(x) + 1;
    ey1 = longint'(y) + 1;
`endif
    ea[0] = ref_addr(base, we, ex0, ey0);
    ea[1] = ref_addr(base, we, ex1, ey0);
    ea[2] = ref_addr(base, we, ex0, ey1);
    ea[3] = ref_addr(base, we, ex1, ey1);
    for (int k = 0; k < 4; k++) ep[k] = mem_fn(ea[k]);

    req_x     = 16'(x);
    req_y     = 16'(y);
    img_w     = 16'(w);
    img_h     = 16'(h);
    base_addr = 19'(base);
    req_valid = 1'b1;
    out_ready = 1'b0;
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("raddr%0d", k), 32'(mem_raddr), 32'(ea[k]));
      check_eq("out_valid_early", 32'(out_valid), 32'd0);
      check_eq("req_ready_busy", 32'(req_ready), 32'd0);
      if (perturb) begin
        req_x     = 16'($urandom);
        req_y     = 16'($urandom);
        img_w     = 16'($urandom);
        img_h     = 16'($urandom);
        base_addr = 19'($urandom);
        req_valid = 1'b1;
      end
      step();
    end
    // Capture state.
    check_eq("out_valid_cap", 32'(out_valid), 32'd0);
    check_eq("raddr_hold_cap", 32'(mem_raddr), 32'(ea[3]));
    step();
    // Fifth edge after accept: quad must be presented.
    check_eq("out_valid", 32'(out_valid), 32'd1);
    check_eq("p00", 32'(p00), 32'(ep[0]));
    check_eq("p01", 32'(p01), 32'(ep[1]));
    check_eq("p10", 32'(p10), 32'(ep[2]));
    check_eq("p11", 32'(p11), 32'(ep[3]));
    for (int s = 0; s < stall; s++) begin
      step();
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      check_eq("stall_quad", {p00, p01, p10, p11}, {ep[0], ep[1], ep[2], ep[3]});
      check_eq("stall_raddr", 32'(mem_raddr), 32'(ea[3]));
    end
    out_ready = 1'b1;
    req_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check_eq("out_valid_drop", 32'(out_valid), 32'd0);
    check_eq("busy_drop", 32'(busy), 32'd0);
    check_eq("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int x, y, w, h;
    rst_n     = 1'b0;
    req_valid = 1'b1;  // reset must win over a pending request
    out_ready = 1'b1;
    req_x     = 16'd5;
    req_y     = 16'd5;
    img_w     = 16'd8;
    img_h     = 16'd8;
    base_addr = 19'd0;
    #1;
    repeat (3) step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_raddr", 32'(mem_raddr), 32'd0);
    check_eq("rst_quad", {p00, p01, p10, p11}, 32'd0);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'b0;
    step();
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);

    // Interior fetch.
    run_fetch(10, 20, 640, 480, 0, 0, 1'b0);
    // Backpressure for 7 cycles, then back-to-back accept.
    run_fetch(100, 200, 640, 480, 1234, 7, 1'b0);
    run_fetch(3, 4, 640, 480, 77, 0, 1'b0);
    // Address wrap: 524287 then 0.
    run_fetch(1, 0, 4, 2, (1 << ADDR_W) - 2, 0, 1'b0);
    // Inputs perturbed during the fetch.
    run_fetch(7, 9, 320, 240, 5000, 2, 1'b1);
`ifdef FETCH_EDGE_CLAMP_EN
    // Bottom-right corner collapses to one pixel.
    run_fetch(639, 479, 640, 480, 0, 0, 1'b0);
    run_fetch(5, 5, 0, 0, 100, 0, 1'b0);
`endif

    // Reset while in A2.
    req_x     = 16'd10;
    req_y     = 16'd20;
    img_w     = 16'd640;
    img_h     = 16'd480;
    base_addr = 19'd0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    out_ready = 1'b0;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_raddr", 32'(mem_raddr), 32'd0);
    check_eq("midrst_quad", {p00, p01, p10, p11}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_eq("midrst_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    run_fetch(10, 20, 640, 480, 0, 1, 1'b0);

    // Random fetches.
    for (int i = 0; i < 40; i++) begin
`ifdef FETCH_EDGE_CLAMP_EN
      w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2048));
      h = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2048));
      x = int'($urandom_range(0, 2050));
      y = int'($urandom_range(0, 2050));
`else
      w = int'($urandom_range(1, 2048));
      h = int'($urandom_range(1, 2048));
      x = int'($urandom_range(0, w - 1));
      y = int'($urandom_range(0, h - 1));
`endif
      run_fetch(x, y, w, h, int'($urandom_range(0, (1 << ADDR_W) - 1)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bilinear_fetch4.md
BILINEAR_FETCH4 -- requirements
Module: bilinear_fetch4

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, meaning image memory address width.
REQ-002 SHALL have parameter DIM_W, default 16, meaning coordinate and dimension width.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning a fetch request is presented.
REQ-006 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 SHALL have port req_x / req_y, input, DIM_W each, meaning top-left source pixel coordinate.
REQ-008 SHALL have port img_w / img_h, input, DIM_W each, meaning image dimensions in pixels.
REQ-009 SHALL have port base_addr, input, ADDR_W, meaning address of pixel (0,0).
REQ-010 SHALL have port mem_raddr, output, ADDR_W, meaning read address to the image memory.
REQ-011 SHALL have port mem_rdata, input, 8, meaning read data, valid one cycle after mem_raddr.
REQ-012 SHALL have port out_valid, output, 1, meaning the neighbour quad is valid.
REQ-013 SHALL have port out_ready, input, 1, meaning the consumer takes the quad.
REQ-014 SHALL have ports p00, p01, p10, p11, output, 8 each, meaning pixels (x0,y0), (x1,y0), (x0,y1), (x1,y1).
REQ-015 SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, A0, A1, A2, A3, CAP, OUT.
REQ-017 SHALL drive req_ready=1 only in IDLE. A request is accepted on a rising edge with req_valid && req_ready, transitioning to A0.
REQ-018 SHALL latch req_x, req_y, img_w, img_h and base_addr on accept. Later changes to these inputs SHALL NOT affect the fetch in progress.
REQ-019 SHALL treat a latched img_w or img_h of 0 as 1.
REQ-020 SHALL compute x0=min(x,W-1), x1=min(x0+1,W-1), y0=min(y,H-1), y1=min(y0+1,H-1); this is the clamp behaviour, see REQ-030.
REQ-021 SHALL form addr(x,y) = (base + y*W + x) mod 2^ADDR_W: full-width product, truncated, wrap-around without error.
REQ-022 SHALL drive mem_raddr as follows: addr(x0,y0) in A0, addr(x1,y0) in A1, addr(x0,y1) in A2, addr(x1,y1) in A3. In other states it SHALL hold its last value.
REQ-023 SHALL capture mem_rdata into p00 at the A1→A2 edge, p01 at A2→A3, p10 at A3→CAP, and p11 at CAP→OUT.
REQ-024 SHALL advance A0→A1→A2→A3→CAP→OUT unconditionally, one state per cycle. out_valid SHALL first be high 5 edges after the accept edge.
REQ-025 SHALL hold out_valid=1 and p00..p11 stable in OUT until out_ready=1. On that edge it SHALL return to IDLE. There is no overlap: the next request can be accepted no earlier than the following edge.
REQ-026 SHALL ignore req_valid in all non-IDLE states. No request is queued.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, enter IDLE and clear mem_raddr, p00..p11, out_valid and busy to 0, with req_ready=1 from the next cycle.
REQ-028 SHALL, on reset mid-fetch (any state A0..OUT), abandon the fetch with no out_valid pulse, and discard partial pixels.
REQ-029 SHALL give reset priority over simultaneous req_valid or out_ready.

Configuration
REQ-030 SHALL support macro FETCH_EDGE_CLAMP_EN. When defined, REQ-019/REQ-020 clamping applies. When undefined, x0=x, y0=y, x1=x+1 and y1=y+1 are taken unclamped; addresses then wrap per REQ-021 and the caller guarantees range.

Verification
REQ-031 SHALL cover interior fetch: W=640, H=480, base=0, x=10, y=20. Required: mem_raddr sequence 12810, 12811, 13450, 13451; quad matches the memory model; out_valid 5 edges after accept.
REQ-032 SHALL cover right/bottom edge with FETCH_EDGE_CLAMP_EN: W=640, H=480, x=639, y=479. Required: all four addresses 307199; p00=p01=p10=p11.
REQ-033 SHALL cover backpressure: out_ready=0 for 7 cycles after out_valid. Required: quad stable, req_ready=0 throughout; accept succeeds on the edge after out_ready=1.
REQ-034 SHALL cover reset in A2: rst_n=0 for one edge. Required: IDLE, out_valid never asserted, outputs 0, next request fetches correctly.
REQ-035 SHALL cover address wrap: base=2^19-2, W=4, x=1, y=0. Required: mem_raddr 524287, then 0.
REQ-036 SHALL cover input changes after accept: req_x/img_w altered during A0..CAP. Required: addresses reflect latched values only.
